// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encoding, op codes and byte-lane width helper for the data-memory responder
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/be_merge.sv
// be_merge: per-byte-lane select between the stored word and incoming write data
module be_merge
    import mem_if_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W = be_width(DATA_W)
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] new_word
);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign new_word[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: clocked word store with 4-phase ready handshake, byte enables, wait states and post-reset clear
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2,
    localparam int BE_W = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [BE_W-1:0]   Mem_BE,
    input  logic [DATA_W-1:0] M_W_Data,
    output logic [DATA_W-1:0] M_R_Data,
    output logic              Mem_Ready,
    output logic              Mem_Err,
    output logic              Mem_Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_addr, addr;
    logic [DATA_W-1:0] wdata, merged;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [BE_W-1:0]   be;
    logic              op;
    logic [CNT_W-1:0]  cnt;
    logic              req, clash, access, clearing;

    assign req      = Mem_Read | Mem_Write;
    assign clash    = Mem_Read & Mem_Write;
    assign access   = (state == ST_WAIT) && (cnt == '0);
    assign clearing = (state == ST_INIT);

    be_merge #(.DATA_W(DATA_W)) u_be_merge (
        .old_word (mem[addr]),
        .wdata    (wdata),
        .be       (be),
        .new_word (merged)
    );

    // next-state: clear sweep, accept, wait countdown, hold response until both requests drop
    always_comb begin
        state_n = state;
        case (state)
            ST_INIT: state_n = (&clr_addr) ? ST_IDLE : ST_INIT;
            ST_IDLE: state_n = !req ? ST_IDLE : clash ? ST_RESP : ST_WAIT;
            ST_WAIT: state_n = (cnt == '0) ? ST_RESP : ST_WAIT;
            ST_RESP: state_n = req ? ST_RESP : ST_IDLE;
            default: state_n = ST_INIT;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? ST_INIT : state_n;
    end

    // request latching, wait counter, clear counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr  <= '0;
            M_R_Data  <= '0;
            Mem_Ready <= 1'b0;
            Mem_Err   <= 1'b0;
            Mem_Busy  <= 1'b1;
        end else begin
            Mem_Ready <= (state_n == ST_RESP);
            Mem_Busy  <= (state_n == ST_INIT);
            if (clearing) clr_addr <= clr_addr + 1'b1;
            if (state == ST_IDLE && req) begin
                addr    <= Mem_Addr;
                wdata   <= M_W_Data;
                be      <= Mem_BE;
                op      <= Mem_Write ? OP_WR : OP_RD;
                cnt     <= CNT_W'(WAIT_CYC);
                Mem_Err <= clash;
            end
            if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (access && op == OP_RD) M_R_Data <= mem[addr];
        end
    end

    // single write port shared by the post-reset clear and byte-lane writes; reset discards a pending write
    always_ff @(posedge clk) begin
        if (!rst && (clearing || (access && op == OP_WR)))
            mem[clearing ? clr_addr : addr] <= clearing ? '0 : merged;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized handshake traffic checked against an array model of the word store
module tb_data_mem_responder;

    localparam int WAIT_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  Mem_Addr = '0;
    logic        Mem_Read = 1'b0;
    logic        Mem_Write = 1'b0;
    logic [3:0]  Mem_BE = '0;
    logic [31:0] M_W_Data = '0;
    logic [31:0] M_R_Data;
    logic        Mem_Ready, Mem_Err, Mem_Busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [64];
    logic [31:0] exp_rd;

    data_mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYC(WAIT_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .Mem_Addr  (Mem_Addr),
        .Mem_Read  (Mem_Read),
        .Mem_Write (Mem_Write),
        .Mem_BE    (Mem_BE),
        .M_W_Data  (M_W_Data),
        .M_R_Data  (M_R_Data),
        .Mem_Ready (Mem_Ready),
        .Mem_Err   (Mem_Err),
        .Mem_Busy  (Mem_Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        int n;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", 32'(Mem_Busy), 32'd1);
        check("rst_ready", 32'(Mem_Ready), 32'd0);
        check("rst_err", 32'(Mem_Err), 32'd0);
        check("rst_rdata", M_R_Data, 32'd0);
        n = 1;
        while (Mem_Busy && n < 200) begin
            @(posedge clk); #1;
            if (Mem_Busy) n++;
        end
        check("busy_cycles", 32'(n), 32'd64);
        foreach (model[i]) model[i] = '0;
        exp_rd = '0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [5:0] a,
                          input logic [3:0] be, input logic [31:0] d, input int hold);
        int   lat;
        logic err;
        Mem_Addr  = a;
        Mem_BE    = be;
        M_W_Data  = d;
        Mem_Read  = rd;
        Mem_Write = wr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            Mem_Addr = 6'($urandom);
            Mem_BE   = 4'($urandom);
            M_W_Data = $urandom;
        end while (!Mem_Ready && lat < 50);
        err = rd & wr;
        if (!err && wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end else if (!err) begin
            exp_rd = model[a];
        end
        check("latency", 32'(lat), err ? 32'd1 : 32'(WAIT_CYC + 2));
        check("err", 32'(Mem_Err), 32'(err));
        check("rdata", M_R_Data, exp_rd);
        repeat (hold) begin
            @(posedge clk); #1;
            Mem_Addr = 6'($urandom);
            check("hold_ready", 32'(Mem_Ready), 32'd1);
            check("hold_rdata", M_R_Data, exp_rd);
        end
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", 32'(Mem_Ready), 32'd0);
        check("idle_rdata", M_R_Data, exp_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        access(1'b1, 1'b0, 6'h3F, 4'h0, 32'h0, 0);
        check("t1_read3f", M_R_Data, 32'h0);

        access(1'b0, 1'b1, 6'd5, 4'hF, 32'h003CC381, 0);
        access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 0);
        check("t2_read5", M_R_Data, 32'h003CC381);

        access(1'b0, 1'b1, 6'd5, 4'b0101, 32'hFFFFFFFF, 0);
        access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 0);
        check("t3_read5", M_R_Data, 32'h00FFC3FF);

        access(1'b1, 1'b1, 6'd7, 4'hF, 32'hFFFFFFFF, 0);
        check("t4_keep", M_R_Data, 32'h00FFC3FF);
        access(1'b1, 1'b0, 6'd7, 4'h0, 32'h0, 0);
        check("t4_read7", M_R_Data, 32'h0);

        access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 5);

        Mem_Addr  = 6'd9;
        Mem_BE    = 4'hF;
        M_W_Data  = 32'hDEADBEEF;
        Mem_Write = 1'b1;
        @(posedge clk); #1;
        repeat (WAIT_CYC) begin @(posedge clk); #1; end
        check("t6_pre_ready", 32'(Mem_Ready), 32'd0);
        do_reset();
        access(1'b1, 1'b0, 6'd9, 4'h0, 32'h0, 0);
        check("t6_read9", M_R_Data, 32'h0);

        for (int k = 0; k < 80; k++) begin
            int          r;
            logic [5:0]  a;
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
            access(r >= 5 || r == 0, r <= 4, a, 4'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
